// File: rtl/eexp_arbiter.sv
// Round-robin arbiter sharing one Q16.16 e^x unit across NUM_REQ requesters.
// Optional operand saturation to [-1.0, +1.0] under EEXP_ARBITER_CLAMP_EN.

module eexp #(
   parameter int TOTAL_BITS      = 32,
   parameter int FRACTIONAL_BITS = 16
) (
   input  logic signed [TOTAL_BITS-1:0] i_x,
   output logic signed [TOTAL_BITS-1:0] o_y
);
   localparam int T = TOTAL_BITS;
   localparam int F = FRACTIONAL_BITS;
   localparam int W = TOTAL_BITS + 34;

   localparam logic signed [W-1:0] LOG2E = W'(1549082005);
   localparam logic signed [W-1:0] KMAX  = W'(T - 1 - F);
   localparam logic signed [W-1:0] SOFF  = W'(F - 30);
   localparam logic [63:0] ONE  = 64'd1073741824;
   localparam logic [63:0] LN2  = 64'd744261118;
   localparam logic [63:0] INV2 = 64'd536870912;
   localparam logic [63:0] INV3 = 64'd357913941;
   localparam logic [63:0] INV4 = 64'd268435456;
   localparam logic [63:0] INV5 = 64'd214748365;
   localparam logic [63:0] INV6 = 64'd178956971;

   logic signed [W-1:0] w_xe;
   logic signed [W-1:0] w_prod;
   logic signed [W-1:0] w_k;
   logic signed [W-1:0] w_s;
   logic signed [W-1:0] w_ns;
   logic [63:0] w_f;
   logic [63:0] w_r;
   logic [63:0] w_p6;
   logic [63:0] w_p5;
   logic [63:0] w_p4;
   logic [63:0] w_p3;
   logic [63:0] w_p2;
   logic [63:0] w_m;

   // e^x = 2^k * e^(f*ln2), k = floor(x*log2e), f its fraction (Q0.30)
   assign w_xe   = W'(i_x);
   assign w_prod = w_xe * LOG2E;
   assign w_k    = w_prod >>> (F + 30);
   assign w_f    = {34'd0, w_prod[F+29:F]};
   assign w_r    = (w_f * LN2) >> 30;

   assign w_p6 = ONE + ((w_r * INV6) >> 30);
   assign w_p5 = ONE + ((((w_r * w_p6) >> 30) * INV5) >> 30);
   assign w_p4 = ONE + ((((w_r * w_p5) >> 30) * INV4) >> 30);
   assign w_p3 = ONE + ((((w_r * w_p4) >> 30) * INV3) >> 30);
   assign w_p2 = ONE + ((((w_r * w_p3) >> 30) * INV2) >> 30);
   assign w_m  = ONE + ((w_r * w_p2) >> 30);

   assign w_s  = w_k + SOFF;
   assign w_ns = -w_s;

   always_comb begin
      o_y = '0;
      if (w_k >= KMAX) begin
         o_y = {1'b0, {(T-1){1'b1}}};
      end else if (!w_s[W-1]) begin
         o_y = T'(w_m << w_s);
      end else if (w_ns > W'(63)) begin
         o_y = '0;
      end else begin
         o_y = T'(w_m >> w_ns);
      end
   end
endmodule

module eexp_arbiter #(
   parameter int NUM_REQ         = 4,
   parameter int TOTAL_BITS      = 32,
   parameter int FRACTIONAL_BITS = 16
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*TOTAL_BITS-1:0] req_x,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [NUM_REQ-1:0]            resp_valid,
   output logic [TOTAL_BITS-1:0]         resp_y,
   output logic                          busy
);
   localparam int PW = $clog2(NUM_REQ);
   localparam int T  = TOTAL_BITS;

   logic [PW-1:0]         r_rr_ptr;
   logic                  r_s1_valid;
   logic [PW-1:0]         r_s1_id;
   logic signed [T-1:0]   r_s1_x;
   logic                  r_s2_valid;
   logic [PW-1:0]         r_s2_id;
   logic signed [T-1:0]   r_s2_y;

   logic                  w_gnt_any;
   logic [PW-1:0]         w_gnt_id;
   logic [PW-1:0]         w_ptr_nxt;
   logic signed [T-1:0]   w_x;
   logic signed [T-1:0]   w_x_in;
   logic signed [T-1:0]   w_y;
   int                    w_idx;

   always_comb begin
      w_gnt_any = 1'b0;
      w_gnt_id  = '0;
      w_idx     = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_idx = (int'(r_rr_ptr) + i) % NUM_REQ;
         if (!w_gnt_any && req_valid[w_idx]) begin
            w_gnt_any = 1'b1;
            w_gnt_id  = PW'(w_idx);
         end
      end
   end

   assign req_ready = w_gnt_any ? (NUM_REQ'(1) << w_gnt_id) : '0;
   assign w_x       = req_x[int'(w_gnt_id)*T +: T];
   assign w_ptr_nxt = (w_gnt_id == PW'(NUM_REQ - 1)) ? '0 : w_gnt_id + 1'b1;

`ifdef EEXP_ARBITER_CLAMP_EN
   localparam logic signed [T-1:0] POS1 = T'(1) << FRACTIONAL_BITS;
   localparam logic signed [T-1:0] NEG1 = -POS1;

   always_comb begin
      w_x_in = w_x;
      if (w_x > POS1) begin
         w_x_in = POS1;
      end else if (w_x < NEG1) begin
         w_x_in = NEG1;
      end
   end
`else
   assign w_x_in = w_x;
`endif

   eexp #(
      .TOTAL_BITS      (TOTAL_BITS),
      .FRACTIONAL_BITS (FRACTIONAL_BITS)
   ) u_eexp (
      .i_x (r_s1_x),
      .o_y (w_y)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rr_ptr   <= '0;
         r_s1_valid <= 1'b0;
         r_s1_id    <= '0;
         r_s1_x     <= '0;
         r_s2_valid <= 1'b0;
         r_s2_id    <= '0;
         r_s2_y     <= '0;
      end else begin
         r_s1_valid <= w_gnt_any;
         if (w_gnt_any) begin
            r_rr_ptr <= w_ptr_nxt;
            r_s1_id  <= w_gnt_id;
            r_s1_x   <= w_x_in;
         end
         r_s2_valid <= r_s1_valid;
         r_s2_id    <= r_s1_id;
         if (r_s1_valid) begin
            r_s2_y <= w_y;
         end
      end
   end

   assign resp_valid = r_s2_valid ? (NUM_REQ'(1) << r_s2_id) : '0;
   assign resp_y     = r_s2_y;
   assign busy       = r_s1_valid | r_s2_valid;
endmodule

// File: tb/tb_eexp_arbiter.sv
// Randomized and directed bench for eexp_arbiter against a real-valued
// exp() reference with a round-robin arbitration model.

module tb_eexp_arbiter;
   localparam int N = 4;
   localparam int T = 32;

   logic           clk = 1'b0;
   logic           reset_n;
   logic [N-1:0]   req_valid;
   logic [N*T-1:0] req_x;
   logic [N-1:0]   req_ready;
   logic [N-1:0]   resp_valid;
   logic [T-1:0]   resp_y;
   logic           busy;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int m_ptr = 0;
   int a_id[int];
   logic [31:0] a_x[int];

   always #5 clk = ~clk;

   eexp_arbiter #(.NUM_REQ(N), .TOTAL_BITS(T), .FRACTIONAL_BITS(16)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req_valid  (req_valid),
      .req_x      (req_x),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_y     (resp_y),
      .busy       (busy)
   );

   function automatic int model_grant(logic [N-1:0] v);
      int j;
      for (int i = 0; i < N; i++) begin
         j = (m_ptr + i) % N;
         if (v[j]) return j;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] onehot(int g);
      logic [N-1:0] o;
      o = '0;
      if (g >= 0) o[g] = 1'b1;
      return o;
   endfunction

   function automatic real ideal(logic [31:0] x);
      real xr;
      real e;
      xr = $itor($signed(x)) / 65536.0;
`ifdef EEXP_ARBITER_CLAMP_EN
      if (xr > 1.0) xr = 1.0;
      if (xr < -1.0) xr = -1.0;
`endif
      if (xr > 22.0) return 2147483647.0;
      e = $exp(xr) * 65536.0;
      if (e > 2147483647.0) e = 2147483647.0;
      return e;
   endfunction

   function automatic bit near(logic [31:0] y, real e);
      real d;
      d = $itor($signed(y)) - e;
      if (d < 0.0) d = -d;
      return d <= e * 0.001 + 4.0;
   endfunction

   task automatic tick(output int g);
      g = reset_n ? model_grant(req_valid) : -1;
      if (g >= 0) begin
         a_id[cyc+2] = g;
         a_x[cyc+2]  = req_x[g*T +: T];
         m_ptr       = (g + 1) % N;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      reset_n   = 1'b0;
      req_valid = '0;
      req_x     = '0;
      a_id.delete();
      a_x.delete();
      m_ptr = 0;
      repeat (2) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      reset_n   = 1'b0;
      req_valid = '0;
      req_x     = '0;
      @(negedge clk);
      total++;
      if (resp_valid !== 4'b0000) begin
         bad++; $display("FAIL reset_resp_valid got=%b want=0000", resp_valid);
      end
      total++;
      if (req_ready !== 4'b0000) begin
         bad++; $display("FAIL reset_req_ready got=%b want=0000", req_ready);
      end
      total++;
      if (busy !== 1'b0) begin
         bad++; $display("FAIL reset_busy got=%b want=0", busy);
      end
      total++;
      if (resp_y !== 32'h0) begin
         bad++; $display("FAIL reset_resp_y got=%h want=00000000", resp_y);
      end
      do_reset();
   endtask

   task automatic test_single();
      int g;
      req_valid = 4'b0001;
      req_x[0 +: T] = 32'h0;
      @(negedge clk);
      total++;
      if (req_ready !== 4'b0001) begin
         bad++; $display("FAIL single_ready got=%b want=0001", req_ready);
      end
      tick(g);
      req_valid = '0;
      @(negedge clk);
      total++;
      if (resp_valid !== 4'b0000 || busy !== 1'b1) begin
         bad++; $display("FAIL single_mid got=%b/%b want=0000/1", resp_valid, busy);
      end
      tick(g);
      @(negedge clk);
      total++;
      if (resp_valid !== 4'b0001) begin
         bad++; $display("FAIL single_resp_valid got=%b want=0001", resp_valid);
      end
      total++;
      if (resp_y !== 32'h0001_0000) begin
         bad++; $display("FAIL single_resp_y got=%h want=00010000", resp_y);
      end
      tick(g);
      @(negedge clk);
      total++;
      if (resp_valid !== 4'b0000 || busy !== 1'b0) begin
         bad++; $display("FAIL single_after got=%b/%b want=0000/0", resp_valid, busy);
      end
   endtask

   task automatic test_back_to_back();
      int g;
      int lo[2] = '{21627, 107480};
      int hi[2] = '{24248, 108134};
      req_valid = 4'b0100;
      req_x[2*T +: T] = 32'hFFFF_0000;
      @(negedge clk);
      total++;
      if (req_ready !== 4'b0100) begin
         bad++; $display("FAIL b2b_ready0 got=%b want=0100", req_ready);
      end
      tick(g);
      req_x[2*T +: T] = 32'h0000_8000;
      @(negedge clk);
      total++;
      if (req_ready !== 4'b0100) begin
         bad++; $display("FAIL b2b_ready1 got=%b want=0100", req_ready);
      end
      tick(g);
      req_valid = '0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         total++;
         if (resp_valid !== 4'b0100) begin
            bad++; $display("FAIL b2b_valid%0d got=%b want=0100", k, resp_valid);
         end
         total++;
         if ($signed(resp_y) < lo[k] || $signed(resp_y) > hi[k]) begin
            bad++; $display("FAIL b2b_y%0d got=%0d want=%0d..%0d", k, $signed(resp_y), lo[k], hi[k]);
         end
         tick(g);
      end
   endtask

   task automatic test_rotation();
      int g;
      int lo[4] = '{65536, 83887, 107480, 137626};
      int hi[4] = '{65536, 84541, 108134, 144179};
      do_reset();
      req_valid = 4'b1111;
      for (int i = 0; i < N; i++) req_x[i*T +: T] = 32'h4000 * i;
      for (int k = 0; k < 10; k++) begin
         if (k == 8) req_valid = '0;
         @(negedge clk);
         total++;
         if (req_ready !== (k < 8 ? onehot(k % 4) : 4'b0000)) begin
            bad++; $display("FAIL rot_ready%0d got=%b want=%b", k, req_ready, (k < 8 ? onehot(k % 4) : 4'b0000));
         end
         if (k >= 2) begin
            total++;
            if (resp_valid !== onehot((k - 2) % 4)) begin
               bad++; $display("FAIL rot_valid%0d got=%b want=%b", k, resp_valid, onehot((k - 2) % 4));
            end
            total++;
            if ($signed(resp_y) < lo[(k-2)%4] || $signed(resp_y) > hi[(k-2)%4]) begin
               bad++; $display("FAIL rot_y%0d got=%0d want=%0d..%0d", k, $signed(resp_y), lo[(k-2)%4], hi[(k-2)%4]);
            end
         end
         tick(g);
      end
   endtask

   task automatic test_ptr_withdraw();
      int g;
      do_reset();
      req_valid = 4'b0010;
      req_x[1*T +: T] = 32'h0000_1000;
      req_x[3*T +: T] = 32'h0000_2000;
      req_x[0*T +: T] = 32'h0000_3000;
      tick(g);
      req_valid = 4'b1010;
      @(negedge clk);
      total++;
      if (req_ready !== 4'b1000) begin
         bad++; $display("FAIL ptr_first got=%b want=1000", req_ready);
      end
      tick(g);
      @(negedge clk);
      total++;
      if (req_ready !== 4'b0010) begin
         bad++; $display("FAIL ptr_second got=%b want=0010", req_ready);
      end
      tick(g);
      req_valid = 4'b0011;
      @(negedge clk);
      total++;
      if (req_ready !== 4'b0001) begin
         bad++; $display("FAIL wd_grant0 got=%b want=0001", req_ready);
      end
      tick(g);
      req_valid = 4'b0000;
      @(negedge clk);
      total++;
      if (req_ready !== 4'b0000) begin
         bad++; $display("FAIL wd_nogrant got=%b want=0000", req_ready);
      end
      for (int k = 0; k < 3; k++) begin
         if (k > 0) @(negedge clk);
         total++;
         if (resp_valid !== (a_id.exists(cyc) ? onehot(a_id[cyc]) : 4'b0000)) begin
            bad++; $display("FAIL wd_resp%0d got=%b want=%b", k, resp_valid, (a_id.exists(cyc) ? onehot(a_id[cyc]) : 4'b0000));
         end
         tick(g);
      end
   endtask

   task automatic test_reset_midflight();
      int g;
      do_reset();
      req_valid = 4'b0001;
      req_x[0 +: T] = 32'h0000_4000;
      tick(g);
      req_valid = 4'b0010;
      req_x[T +: T] = 32'h0000_8000;
      tick(g);
      reset_n   = 1'b0;
      req_valid = '0;
      a_id.delete();
      a_x.delete();
      m_ptr = 0;
      #1;
      total++;
      if (busy !== 1'b0 || resp_valid !== 4'b0000) begin
         bad++; $display("FAIL mid_reset_now got=%b/%b want=0/0000", busy, resp_valid);
      end
      tick(g);
      reset_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         total++;
         if (resp_valid !== 4'b0000 || busy !== 1'b0) begin
            bad++; $display("FAIL mid_reset_quiet%0d got=%b/%b want=0000/0", k, resp_valid, busy);
         end
         tick(g);
      end
      req_valid = 4'b1111;
      @(negedge clk);
      total++;
      if (req_ready !== 4'b0001) begin
         bad++; $display("FAIL mid_reset_ptr got=%b want=0001", req_ready);
      end
      req_valid = '0;
      tick(g);
      repeat (2) tick(g);
   endtask

   task automatic test_clamp();
      int g;
      do_reset();
      req_valid = 4'b0001;
      req_x[0 +: T] = 32'h0002_0000;
      tick(g);
      req_valid = '0;
      tick(g);
      @(negedge clk);
      total++;
      if (resp_valid !== 4'b0001) begin
         bad++; $display("FAIL clamp_valid got=%b want=0001", resp_valid);
      end
`ifdef EEXP_ARBITER_CLAMP_EN
      total++;
      if ($signed(resp_y) <= 174325 || $signed(resp_y) >= 178258) begin
         bad++; $display("FAIL clamp_y got=%0d want=174326..178257", $signed(resp_y));
      end
`else
      total++;
      if (!near(resp_y, $exp(2.0) * 65536.0)) begin
         bad++; $display("FAIL noclamp_y got=%0d want=%0f", $signed(resp_y), $exp(2.0) * 65536.0);
      end
`endif
      tick(g);
   endtask

   function automatic logic [31:0] rand_x();
      int sel;
      sel = $urandom_range(0, 19);
      if (sel == 0) return 32'h7FFF_FFFF;
      if (sel == 1) return 32'h8000_0000;
      return 32'($urandom_range(0, 22 * 65536)) - 32'(12 * 65536);
   endfunction

   task automatic test_random();
      int g;
      logic [N-1:0] ev;
      do_reset();
      for (int c = 0; c < 300; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!req_valid[i]) begin
               if ($urandom_range(0, 1) == 1) begin
                  req_valid[i] = 1'b1;
                  req_x[i*T +: T] = rand_x();
               end
            end else if ($urandom_range(0, 15) == 0) begin
               req_valid[i] = 1'b0;
            end
         end
         @(negedge clk);
         total++;
         if (req_ready !== onehot(model_grant(req_valid))) begin
            bad++; $display("FAIL rnd_ready c=%0d got=%b want=%b", c, req_ready, onehot(model_grant(req_valid)));
         end
         ev = a_id.exists(cyc) ? onehot(a_id[cyc]) : '0;
         total++;
         if (resp_valid !== ev) begin
            bad++; $display("FAIL rnd_valid c=%0d got=%b want=%b", c, resp_valid, ev);
         end
         if (ev != '0) begin
            total++;
            if (!near(resp_y, ideal(a_x[cyc]))) begin
               bad++; $display("FAIL rnd_y c=%0d x=%h got=%0d want=%0f", c, a_x[cyc], $signed(resp_y), ideal(a_x[cyc]));
            end
         end
         total++;
         if (busy !== (a_id.exists(cyc) || a_id.exists(cyc + 1))) begin
            bad++; $display("FAIL rnd_busy c=%0d got=%b", c, busy);
         end
         tick(g);
         if (g >= 0) begin
            req_valid[g] = ($urandom_range(0, 1) == 1);
            req_x[g*T +: T] = rand_x();
         end
      end
      req_valid = '0;
      repeat (3) tick(g);
   endtask

   initial begin
      reset_n   = 1'b0;
      req_valid = '0;
      req_x     = '0;
      test_reset();
      test_single();
      test_back_to_back();
      test_rotation();
      test_ptr_withdraw();
      test_reset_midflight();
      test_clamp();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
